div_iter_exec_unit: RTL and testbench

//  Iterative radix-2 divide/remainder execution unit for the RV32M divide group (DIV/DIVU/REM/REMU).

---
 rtl/div_iter_exec_unit.sv | 156 +++++++++++++++
 tb/tb_div_iter_exec_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_exec_unit.sv
// rtl/div_iter_exec_unit.sv - iterative radix-2 RV32M divide/remainder unit with CDB handshake
module div_iter_exec_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_granted,
   input  logic [1:0]       i_op,
   input  logic [XLEN-1:0]  i_rs1_data,
   input  logic [XLEN-1:0]  i_rs2_data,
   input  logic [TAG_W-1:0] i_rd_tag,
   input  logic             i_flush,
   input  logic             i_cdb_grant,
   output logic             o_cdb_valid,
   output logic [TAG_W-1:0] o_cdb_tag,
   output logic [XLEN-1:0]  o_cdb_result,
   output logic             o_cdb_branch,
   output logic             o_busy
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

   state_t           state, state_nx;
   logic [1:0]       op_r;
   logic [XLEN-1:0]  a_r, b_r, quo_r, rem_r, res_r;
   logic [TAG_W-1:0] tag_r;
   logic [CNT_W-1:0] cnt_r;
   logic             q_neg_r, r_neg_r, special_r, busy_r, valid_r;

   // op_r[0]=0 selects the signed flavours (DIV/REM), op_r[1]=1 selects remainder
   logic             is_signed, div_zero, ovf, special_now;
   logic [XLEN-1:0]  a_abs, b_abs, special_res, q_fin, r_fin;
   logic [XLEN:0]    r_sh;
   logic             r_ge;

   // special-case detection, magnitude extraction and one restoring step
   always_comb begin
      is_signed   = ~op_r[0];
      div_zero    = (b_r == '0);
      ovf         = is_signed && (a_r == MIN_INT) && (b_r == '1);
      special_now = div_zero || ovf;
      a_abs       = (is_signed && a_r[XLEN-1]) ? -a_r : a_r;
      b_abs       = (is_signed && b_r[XLEN-1]) ? -b_r : b_r;
      if (div_zero)
         special_res = op_r[1] ? a_r : '1;
      else
         special_res = op_r[1] ? '0 : MIN_INT;
      r_sh  = {rem_r, quo_r[XLEN-1]};
      r_ge  = (r_sh >= {1'b0, b_r});
      q_fin = q_neg_r ? -quo_r : quo_r;
      r_fin = r_neg_r ? -rem_r : rem_r;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // next-state decode; flush overrides every state
   always_comb begin
      state_nx = state;
      if (i_flush) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (issue_granted) state_nx = S_PREP;
            S_PREP: state_nx = special_now ? S_FIX : S_ITER;
            S_ITER: if (cnt_r == CNT_LAST) state_nx = S_FIX;
            S_FIX:  state_nx = S_DONE;
            S_DONE: if (i_cdb_grant) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // operand capture, shift-subtract datapath and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r      <= '0;
         a_r       <= '0;
         b_r       <= '0;
         tag_r     <= '0;
         cnt_r     <= '0;
         quo_r     <= '0;
         rem_r     <= '0;
         res_r     <= '0;
         q_neg_r   <= 1'b0;
         r_neg_r   <= 1'b0;
         special_r <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (issue_granted && !i_flush) begin
                  op_r  <= i_op;
                  a_r   <= i_rs1_data;
                  b_r   <= i_rs2_data;
                  tag_r <= i_rd_tag;
               end
            end
            S_PREP: begin
               quo_r     <= a_abs;
               b_r       <= b_abs;
               rem_r     <= '0;
               cnt_r     <= '0;
               q_neg_r   <= is_signed && (a_r[XLEN-1] ^ b_r[XLEN-1]);
               r_neg_r   <= is_signed && a_r[XLEN-1];
               special_r <= special_now;
               res_r     <= special_res;
            end
            S_ITER: begin
               // the shifted partial remainder is always below 2*|b|, so one subtract suffices
               if (r_ge) begin
                  rem_r <= r_sh[XLEN-1:0] - b_r;
                  quo_r <= {quo_r[XLEN-2:0], 1'b1};
               end else begin
                  rem_r <= r_sh[XLEN-1:0];
                  quo_r <= {quo_r[XLEN-2:0], 1'b0};
               end
               cnt_r <= cnt_r + CNT_W'(1);
            end
            S_FIX: begin
               // special results were already loaded in PREP and pass through untouched
               if (!special_r)
                  res_r <= op_r[1] ? r_fin : q_fin;
            end
            default: ;
         endcase
      end
   end

   // registered status flags decoded from the upcoming state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         busy_r  <= (state_nx != S_IDLE);
         valid_r <= (state_nx == S_DONE);
      end
   end

   assign o_busy       = busy_r;
   assign o_cdb_valid  = valid_r;
   assign o_cdb_tag    = valid_r ? tag_r : '0;
   assign o_cdb_result = valid_r ? res_r : '0;
   assign o_cdb_branch = 1'b0;

endmodule

// File: tb/tb_div_iter_exec_unit.sv
// tb/tb_div_iter_exec_unit.sv - directed and randomized checks of div_iter_exec_unit
module tb_div_iter_exec_unit;

   localparam logic [31:0] MIN_INT = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        issue_granted = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic [5:0]  rd_tag = '0;
   logic        flush = 1'b0;
   logic        cdb_grant = 1'b0;
   logic        cdb_valid;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_result;
   logic        cdb_branch;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   div_iter_exec_unit #(.XLEN(32), .TAG_W(6)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_granted(issue_granted),
      .i_op         (op),
      .i_rs1_data   (rs1),
      .i_rs2_data   (rs2),
      .i_rd_tag     (rd_tag),
      .i_flush      (flush),
      .i_cdb_grant  (cdb_grant),
      .o_cdb_valid  (cdb_valid),
      .o_cdb_tag    (cdb_tag),
      .o_cdb_result (cdb_result),
      .o_cdb_branch (cdb_branch),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      case (f)
         2'b00: if (b == 0) ref_div = '1;
                else if (a == MIN_INT && b == '1) ref_div = MIN_INT;
                else ref_div = sa / sb;
         2'b01: ref_div = (b == 0) ? '1 : a / b;
         2'b10: if (b == 0) ref_div = a;
                else if (a == MIN_INT && b == '1) ref_div = '0;
                else ref_div = sa % sb;
         default: ref_div = (b == 0) ? a : a % b;
      endcase
   endfunction

   // issue one op, wait for the result, hold grant low for `hold` cycles, then grant
   task automatic run_op(input string name, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] t, input logic [31:0] exp,
                         input int exp_lat, input int hold, input bit poke);
      int lat;
      @(negedge clk);
      issue_granted = 1'b1;
      op = f; rs1 = a; rs2 = b; rd_tag = t;
      @(posedge clk);
      @(negedge clk);
      issue_granted = 1'b0;
      check_eq({name, " busy_after_accept"}, 32'(busy), 32'd1);
      lat = 0;
      while (!cdb_valid && lat < 100) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check_eq({name, " latency"}, lat, exp_lat);
      check_eq({name, " tag"}, 32'(cdb_tag), 32'(t));
      check_eq({name, " result"}, cdb_result, exp);
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            issue_granted = 1'b1;
            op = 2'b01; rs1 = 32'd77; rs2 = 32'd7; rd_tag = 6'h3F;
         end
         @(posedge clk);
         @(negedge clk);
         check_eq({name, " hold_valid"}, 32'(cdb_valid), 32'd1);
         check_eq({name, " hold_tag"}, 32'(cdb_tag), 32'(t));
         check_eq({name, " hold_result"}, cdb_result, exp);
         check_eq({name, " hold_busy"}, 32'(busy), 32'd1);
      end
      issue_granted = 1'b0;
      cdb_grant = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cdb_grant = 1'b0;
      check_eq({name, " valid_after_grant"}, 32'(cdb_valid), 32'd0);
      check_eq({name, " busy_after_grant"}, 32'(busy), 32'd0);
      check_eq({name, " result_idle"}, cdb_result, 32'd0);
   endtask

   initial begin
      bit saw_valid;
      int lat;
      logic [1:0]  f;
      logic [31:0] a, b;
      int sel, el;

      // reset state
      #12;
      check_eq("reset_valid", 32'(cdb_valid), 32'd0);
      check_eq("reset_busy", 32'(busy), 32'd0);
      check_eq("reset_tag", 32'(cdb_tag), 32'd0);
      check_eq("reset_result", cdb_result, 32'd0);
      check_eq("branch_tied", 32'(cdb_branch), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // directed vectors
      run_op("div_100_7",   2'b00, 32'd100,        32'd7,          6'd5,  32'd14,         34, 0, 0);
      run_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9,  32'd2,          6'd6,  32'hFFFF_FFFF,  34, 0, 0);
      run_op("div_m7_2",    2'b00, 32'hFFFF_FFF9,  32'd2,          6'd7,  32'hFFFF_FFFD,  34, 1, 0);
      run_op("divu_max_2",  2'b01, 32'hFFFF_FFFF,  32'd2,          6'd8,  32'h7FFF_FFFF,  34, 0, 0);
      run_op("div_x_0",     2'b00, 32'd1234567,    32'd0,          6'd9,  32'hFFFF_FFFF,  2,  0, 0);
      run_op("remu_x_0",    2'b11, 32'h0000_1234,  32'd0,          6'd10, 32'h0000_1234,  2,  0, 0);
      run_op("div_ovf",     2'b00, MIN_INT,        32'hFFFF_FFFF,  6'd11, MIN_INT,        2,  0, 0);
      run_op("rem_ovf",     2'b10, MIN_INT,        32'hFFFF_FFFF,  6'd12, 32'd0,          2,  0, 0);
      run_op("divu_no_ovf", 2'b01, MIN_INT,        32'hFFFF_FFFF,  6'd13, 32'd0,          34, 0, 0);
      run_op("rem_7_m3",    2'b10, 32'd7,          32'hFFFF_FFFD,  6'd14, 32'd1,          34, 0, 0);

      // backpressure: 10 cycles without grant, stray issues ignored
      run_op("hold_div",    2'b00, 32'd1000,       32'd33,         6'd21, 32'd30,         34, 10, 1);

      // flush during ITER at count 10
      @(negedge clk);
      issue_granted = 1'b1;
      op = 2'b00; rs1 = 32'd100; rs2 = 32'd7; rd_tag = 6'd30;
      @(posedge clk);
      @(negedge clk);
      issue_granted = 1'b0;
      repeat (11) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      check_eq("flush_busy", 32'(busy), 32'd0);
      check_eq("flush_valid", 32'(cdb_valid), 32'd0);
      saw_valid = 1'b0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (cdb_valid) saw_valid = 1'b1;
      end
      check_eq("flush_no_result", 32'(saw_valid), 32'd0);
      run_op("divu_9_3",    2'b01, 32'd9,          32'd3,          6'd31, 32'd3,          34, 0, 0);

      // flush together with issue in IDLE: nothing accepted
      @(negedge clk);
      issue_granted = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      issue_granted = 1'b0;
      flush = 1'b0;
      check_eq("flush_issue_busy", 32'(busy), 32'd0);

      // flush together with grant in DONE
      @(negedge clk);
      issue_granted = 1'b1;
      op = 2'b01; rs1 = 32'd20; rs2 = 32'd4; rd_tag = 6'd3;
      @(posedge clk);
      @(negedge clk);
      issue_granted = 1'b0;
      lat = 0;
      while (!cdb_valid && lat < 100) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check_eq("fg_result", cdb_result, 32'd5);
      flush = 1'b1;
      cdb_grant = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      cdb_grant = 1'b0;
      check_eq("fg_busy", 32'(busy), 32'd0);
      check_eq("fg_valid", 32'(cdb_valid), 32'd0);

      // asynchronous reset mid-operation
      @(negedge clk);
      issue_granted = 1'b1;
      op = 2'b00; rs1 = 32'd500; rs2 = 32'd9; rd_tag = 6'd4;
      @(posedge clk);
      @(negedge clk);
      issue_granted = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_busy", 32'(busy), 32'd0);
      check_eq("arst_valid", 32'(cdb_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_arst",  2'b11, 32'd500,        32'd9,          6'd2,  32'd5,          34, 0, 0);

      // randomized regression against the behavioural model
      for (int i = 0; i < 200; i++) begin
         f   = 2'($urandom_range(0, 3));
         sel = $urandom_range(0, 7);
         a   = (sel == 0) ? MIN_INT : $urandom;
         case (sel)
            1:       b = 32'd0;
            0, 2:    b = 32'hFFFF_FFFF;
            3:       b = $urandom_range(1, 15);
            4:       b = -32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         el = ((b == 0) || (!f[0] && a == MIN_INT && b == 32'hFFFF_FFFF)) ? 2 : 34;
         run_op("rand", f, a, b, 6'($urandom), ref_div(f, a, b), el, $urandom_range(0, 3), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
